// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: RISC-V store funct3 codes and the
// store_unit FSM state encoding.
package store_unit_pkg;

    localparam logic [2:0] INST_SB = 3'b000;
    localparam logic [2:0] INST_SH = 3'b001;
    localparam logic [2:0] INST_SW = 3'b010;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WR   = 2'd1;
    localparam logic [1:0] STATE_RD   = 2'd2;
    localparam logic [1:0] STATE_MG   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_WR   = STATE_WR,
        ST_RD   = STATE_RD,
        ST_MG   = STATE_MG
    } state_t;

endpackage

// File: rtl/store_unit_if.sv
// Execute-stage request, data BRAM port and status signals of the store unit.
interface store_unit_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  busy;
    logic                  done;
    logic                  misalign;

    // Store unit side.
    modport slave (
        input  req_valid, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_we, mem_wdata, busy, done, misalign
    );

    // CPU / memory side.
    modport master (
        output req_valid, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_we, mem_wdata, busy, done, misalign
    );
endinterface

// File: rtl/store_unit_lane_merge.sv
// Merges a byte or halfword store into the old BRAM word; SW passes new data.
module store_lane_merge
    import store_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane_addr,
    output logic [31:0] merged
);

    // Replace the addressed lane, keep every other byte of the old word.
    always_comb begin
        merged = old_word;
        case (funct3)
            INST_SB: begin
                case (lane_addr)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    2'd3:    merged[31:24] = new_data[7:0];
                    default: merged        = old_word;
                endcase
            end
            INST_SH: begin
                if (lane_addr[1]) begin
                    merged[31:16] = new_data[15:0];
                end else begin
                    merged[15:0] = new_data[15:0];
                end
            end
            INST_SW: merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: SW written directly, SB/SH done as read-modify-write on a
// BRAM without byte enables. busy stalls the CPU while a store is in flight.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst,
    store_unit_if.slave bus
);

    state_t                state_r;
    state_t                state_next_s;
    state_t                accept_target_s;
    logic [2:0]            funct3_r;
    logic [ADDR_WIDTH+1:0] addr_r;
    logic [31:0]           data_r;
    logic                  misalign_r;
    logic                  accept_s;
    logic                  reject_s;
    logic [31:0]           merged_s;
    logic                  req_ready_s;
    logic                  mem_we_s;
    logic                  done_s;
    logic                  busy_s;
    logic [31:0]           mem_wdata_s;
    logic                  unused_addr_s;

    // Address bits above the BRAM range are ignored: the word address wraps.
    assign unused_addr_s = ^bus.req_addr[31:ADDR_WIDTH+2];
    assign accept_s      = (state_r == ST_IDLE) && bus.req_valid;

    // Decode the incoming request into its first state or a rejection.
    always_comb begin
        reject_s        = 1'b0;
        accept_target_s = ST_IDLE;
        case (bus.req_funct3)
            INST_SW: begin
                if (bus.req_addr[1:0] == 2'b00) begin
                    accept_target_s = ST_WR;
                end else begin
                    reject_s = 1'b1;
                end
            end
            INST_SH: begin
                if (bus.req_addr[0] == 1'b0) begin
                    accept_target_s = ST_RD;
                end else begin
                    reject_s = 1'b1;
                end
            end
            INST_SB: accept_target_s = ST_RD;
            default: reject_s = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = accept_target_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR:   state_next_s = ST_IDLE;
            ST_RD:   state_next_s = ST_MG;
            ST_MG:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state outputs; reset forces IDLE so a pending write drops at once.
    always_comb begin
        req_ready_s = 1'b0;
        mem_we_s    = 1'b0;
        done_s      = 1'b0;
        busy_s      = 1'b1;
        mem_wdata_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_WR, ST_MG: begin
                mem_we_s    = 1'b1;
                done_s      = 1'b1;
                mem_wdata_s = merged_s;
            end
            ST_RD:   mem_we_s = 1'b0;
            default: busy_s   = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the request on accept, including ones that get rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_r <= 3'b000;
            addr_r   <= '0;
            data_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr[ADDR_WIDTH+1:0];
            data_r   <= bus.req_wdata;
        end
    end

    // One-cycle rejection pulse in the cycle after the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= accept_s && reject_s;
        end
    end

    store_lane_merge u_merge (
        .old_word  (bus.mem_rdata),
        .new_data  (data_r),
        .funct3    (funct3_r),
        .lane_addr (addr_r[1:0]),
        .merged    (merged_s)
    );

    assign bus.req_ready = req_ready_s;
    assign bus.mem_addr  = addr_r[ADDR_WIDTH+1:2];
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.misalign  = misalign_r;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed stores push expected BRAM writes
// and rejection pulses; a negedge monitor pops and compares them.
module tb_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    int      mis_q[$];
    logic [31:0] bram [0:16383];

    store_unit_if #(.ADDR_WIDTH(14)) bus ();

    store_unit #(.ADDR_WIDTH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first single-port BRAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bram[bus.mem_addr];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every BRAM write and rejection pulse must match an expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("done_eq_we", {31'd0, bus.done}, {31'd0, bus.mem_we});
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", {18'd0, bus.mem_addr}, {18'd0, e.addr});
                    check("wr_data", bus.mem_wdata, e.data);
                end
            end
            if (bus.misalign) begin
                if (mis_q.size() == 0) begin
                    check("unexpected_misalign", 32'd1, 32'd0);
                end else begin
                    check("misalign_cycle", cyc, mis_q.pop_front());
                end
            end
        end
    end

    // kind: 0 = no expectation, 1 = write, 2 = misalign. wr_cyc is the cycle
    // number counting the accept edge as cycle 0.
    task automatic send(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input int kind,
                        input logic [13:0] exp_addr, input logic [31:0] exp_data,
                        input int wr_cyc, output int acc);
        bit got;
        wr_exp_t e;
        got = 1'b0;
        acc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_funct3 = f3;
            bus.req_addr   = addr;
            bus.req_wdata  = data;
            if (bus.req_ready) begin
                got = 1'b1;
                acc = cyc + 1;
            end
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (kind == 1) begin
            e.cyc  = acc + wr_cyc - 1;
            e.addr = exp_addr;
            e.data = exp_data;
            wr_q.push_back(e);
        end else if (kind == 2) begin
            mis_q.push_back(acc);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    initial begin
        int a0;
        int a1;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        check("rst_addr", {18'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;

        // SW direct write; busy high for exactly one cycle.
        send(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1, 14'd4, 32'hDEAD_BEEF, 1, a0);
        @(negedge clk);
        check("sw_busy_c1", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("sw_busy_c2", {31'd0, bus.busy}, 32'd0);

        // SB / SH read-modify-write into word 4 = 0x11223344.
        send(3'b010, 32'h0000_0010, 32'h1122_3344, 1, 14'd4, 32'h1122_3344, 1, a0);
        send(3'b000, 32'h0000_0012, 32'h0000_00AA, 1, 14'd4, 32'h11AA_3344, 2, a0);
        send(3'b010, 32'h0000_0010, 32'h1122_3344, 1, 14'd4, 32'h1122_3344, 1, a0);
        send(3'b001, 32'h0000_0012, 32'h0000_BEEF, 1, 14'd4, 32'hBEEF_3344, 2, a0);

        // Rejected requests: no memory access, unit stays ready.
        send(3'b001, 32'h0000_0013, 32'h0000_1111, 2, 14'd0, 32'd0, 0, a0);
        @(negedge clk);
        check("mis_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mis_busy", {31'd0, bus.busy}, 32'd0);
        send(3'b010, 32'h0000_0006, 32'h2222_2222, 2, 14'd0, 32'd0, 0, a0);
        send(3'b100, 32'h0000_0010, 32'h3333_3333, 2, 14'd0, 32'd0, 0, a0);

        // Back-to-back SBs into a zeroed word.
        send(3'b010, 32'h0000_0010, 32'h0000_0000, 1, 14'd4, 32'h0000_0000, 1, a0);
        send(3'b000, 32'h0000_0010, 32'h0000_0055, 1, 14'd4, 32'h0000_0055, 2, a0);
        send(3'b000, 32'h0000_0011, 32'h0000_0066, 1, 14'd4, 32'h0000_6655, 2, a1);
        check("b2b_spacing", a1 - a0, 32'd3);

        // Address wrap, SB in lane 3, SH in the low half.
        send(3'b010, 32'h0001_0008, 32'hCAFE_F00D, 1, 14'd2, 32'hCAFE_F00D, 1, a0);
        send(3'b000, 32'h0000_000B, 32'h0000_0077, 1, 14'd2, 32'h77FE_F00D, 2, a0);
        send(3'b001, 32'h0000_0008, 32'h0000_1234, 1, 14'd2, 32'h77FE_1234, 2, a0);

        // Reset in the RD cycle of an SB: nothing is written.
        send(3'b000, 32'h0000_000A, 32'h0000_0099, 0, 14'd0, 32'd0, 0, a0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_we", {31'd0, bus.mem_we}, 32'd0);
        check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rstmid_addr", {18'd0, bus.mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_word", bram[2], 32'h77FE_1234);

        // The reissued SB completes normally.
        send(3'b000, 32'h0000_000A, 32'h0000_0099, 1, 14'd2, 32'h7799_1234, 2, a0);

        repeat (5) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("mis_q_drained", mis_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-path counterpart of the register-writeback load extension: executes SB/SH/SW into a single-port data BRAM that has no byte enables.
- SW is written directly. SB/SH use read-modify-write, merging the new byte or halfword into the existing word.
- Sits between the execute stage and data memory; asserts busy to stall the CPU while a store is in flight.

Parameters:
- ADDR_WIDTH, 14, word-address width of the data BRAM (16K words)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  store request from execute stage
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_funct3  in  3  store funct3: 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  rs2 data
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after mem_addr is presented
- busy  out  1  high whenever state is not IDLE (CPU stall)
- done  out  1  one-cycle pulse in the cycle the BRAM write is issued
- misalign  out  1  one-cycle pulse: request rejected (misaligned or illegal funct3)

Behaviour:
- Reset (asynchronous, any cycle):
  - state returns to IDLE; latched addr, data and funct3 clear to 0.
  - mem_we=0, done=0, misalign=0, busy=0, req_ready=1.
  - mem_addr=0, mem_wdata=0.
- Reset mid-operation:
  - mem_we drops immediately; no partial or merged write is issued.
  - The pending request is discarded; the CPU reissues it.
- States: IDLE, WR, RD, MG.
- IDLE:
  - Accept when req_valid && req_ready; latch funct3, req_addr and req_wdata.
  - SW with addr[1:0]==0: go to WR.
  - SB (any alignment), or SH with addr[0]==0: go to RD.
  - SH with addr[0]==1, SW with addr[1:0]!=0, or funct3 not in {000,001,010}: stay in IDLE, pulse misalign next cycle, no memory access.
- WR (one cycle):
  - mem_addr = latched addr[ADDR_WIDTH+1:2]; mem_we=1; mem_wdata = latched data; done=1.
  - Go to IDLE.
- RD (one cycle):
  - mem_addr = latched word address; mem_we=0.
  - Go to MG.
- MG (one cycle):
  - mem_rdata now holds the old word.
  - mem_we=1, same mem_addr, mem_wdata = merged word; done=1.
  - Go to IDLE.
- Merge rules:
  - SB: lane = addr[1:0]; bits [8*lane+7:8*lane] replaced by wdata[7:0]; the other three bytes are kept.
  - SH: lane = addr[1]; bits [16*lane+15:16*lane] replaced by wdata[15:0]; the other half is kept.
- Latency, counting the accept edge as cycle 0:
  - SW: write in cycle 1.
  - SB/SH: read in cycle 1, write in cycle 2.
  - Back-to-back requests: accepted in the first IDLE cycle after the write (SW: one every 2 cycles, SB/SH: one every 3).
- Outputs in IDLE: mem_we=0, done=0; mem_addr holds the last latched word address.
- busy is combinational from state, so the stall asserts in the cycle after accept.
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so the word address wraps modulo 2^ADDR_WIDTH.
- Ordering: an SB directly after a write to the same word reads in a later cycle than that write, so it sees the committed data; no forwarding is needed.
- req_valid while busy: ignored (req_ready=0); the requester holds its inputs stable until accepted.

Decomposition:
- Shared header (RISC-V defs):
  - store funct3 constants INST_SB=3'b000, INST_SH=3'b001, INST_SW=3'b010.
  - state encoding localparams.
- One sub-module: store_lane_merge (combinational). Inputs: old word, new data, funct3, addr[1:0]. Output: merged word.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF -> cycle 1: mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1; busy high one cycle.
- Word 4 = 0x11223344; SB addr 0x12, data 0x000000AA -> cycle 1 read of addr 4; cycle 2 write 0x11AA3344, done=1.
- Word 4 = 0x11223344; SH addr 0x12, data 0x0000BEEF -> cycle 2 write 0xBEEF3344.
- SH addr 0x13 and SW addr 0x06 -> misalign pulse each, mem_we never 1, req_ready stays 1.
- SB 0x10 data 0x55 immediately followed by SB 0x11 data 0x66, word initially 0 -> writes 0x00000055 then 0x00006655; second request accepted in the cycle after the first write.
- rst asserted in the RD cycle of an SB -> mem_we stays 0, state IDLE, busy=0; word unchanged.
